// File: rtl/rf_port_sched_if.sv
// Bundle of issue, writeback, long-unit and register-file write-port signals for rf_port_sched.
// The master side is the surrounding pipeline and the slave side is the scheduler.
interface rf_port_sched_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          iss_valid;
   logic [AW-1:0] iss_rs;
   logic [AW-1:0] iss_rt;
   logic [AW-1:0] iss_rd;
   logic          iss_wr;
   logic          iss_long;
   logic          iss_stall;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          lu_valid;
   logic [AW-1:0] lu_addr;
   logic [DW-1:0] lu_data;
   logic          lu_ready;
   logic          rf_wr;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;
   logic [31:0]   pend;

   modport master (
      output iss_valid, iss_rs, iss_rt, iss_rd, iss_wr, iss_long,
      output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
      input  iss_stall, lu_ready, rf_wr, rf_addr, rf_data, pend
   );

   modport slave (
      input  iss_valid, iss_rs, iss_rt, iss_rd, iss_wr, iss_long,
      input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
      output iss_stall, lu_ready, rf_wr, rf_addr, rf_data, pend
   );
endinterface

// File: rtl/rf_port_sched.sv
// Register-file write-port arbiter (WB over long unit, 1-cycle registered write) plus long-op scoreboard.
// WB is never refused; the long unit is held off by lu_ready, and issue is held off by iss_stall.
module rf_port_sched #(
   parameter int AW         = 5,
   parameter int DW         = 32,
   parameter int MAX_LONG   = 4,
   parameter int STARVE_LIM = 8
) (
   input logic        clk,
   input logic        reset,
   rf_port_sched_if.slave bus
);
   localparam int CW = 4;
   localparam int SW = $clog2(STARVE_LIM + 1);

   logic [31:0]   r_pend;
   logic [CW-1:0] r_cnt;
   logic [SW-1:0] r_starve;
   logic          r_rf_wr;
   logic [AW-1:0] r_rf_addr;
   logic [DW-1:0] r_rf_data;

   logic          w_lu_ready;
   logic          w_gnt;
   logic [AW-1:0] w_gnt_addr;
   logic [DW-1:0] w_gnt_data;
   logic          w_haz;
   logic          w_full;
   logic          w_starve_force;
   logic          w_stall;
   logic          w_fire;
   logic          w_set;
   logic          w_acc;
   logic          w_dec;
   logic [31:0]   w_pend_nxt;
   logic [CW-1:0] w_cnt_nxt;

   assign w_lu_ready = bus.lu_valid & ~bus.wb_valid;
   assign w_gnt      = bus.wb_valid | bus.lu_valid;
   assign w_gnt_addr = bus.wb_valid ? bus.wb_addr : bus.lu_addr;
   assign w_gnt_data = bus.wb_valid ? bus.wb_data : bus.lu_data;

   // Stall decisions look only at registered state; no same-cycle bypass of a retiring long op.
   assign w_haz          = r_pend[bus.iss_rs] | r_pend[bus.iss_rt] | (bus.iss_wr & r_pend[bus.iss_rd]);
   assign w_full         = bus.iss_long & (r_cnt == CW'(MAX_LONG));
   assign w_starve_force = (r_starve >= SW'(STARVE_LIM));
   assign w_stall        = bus.iss_valid & (w_haz | w_full | w_starve_force);

   assign w_fire = bus.iss_valid & ~w_stall;
   assign w_set  = w_fire & bus.iss_wr & bus.iss_long;
   assign w_acc  = bus.lu_valid & w_lu_ready;
   // An accept with nothing outstanding is a protocol error and leaves the scoreboard alone.
   assign w_dec  = w_acc & (r_cnt != '0);

   always_comb begin
      w_pend_nxt = r_pend;
      if (w_dec) begin
         w_pend_nxt[bus.lu_addr] = 1'b0;
      end
      if (w_set && (bus.iss_rd != '0)) begin
         w_pend_nxt[bus.iss_rd] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_set, w_dec})
         2'b10:   w_cnt_nxt = r_cnt + CW'(1);
         2'b01:   w_cnt_nxt = r_cnt - CW'(1);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend    <= '0;
         r_cnt     <= '0;
         r_starve  <= '0;
         r_rf_wr   <= 1'b0;
         r_rf_addr <= '0;
         r_rf_data <= '0;
      end else begin
         r_pend  <= w_pend_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rf_wr <= w_gnt & (w_gnt_addr != '0);
         if (w_gnt) begin
            r_rf_addr <= w_gnt_addr;
            r_rf_data <= w_gnt_data;
         end
         if (!bus.lu_valid || w_acc) begin
            r_starve <= '0;
         end else if (r_starve < SW'(STARVE_LIM)) begin
            r_starve <= r_starve + SW'(1);
         end
      end
   end

   assign bus.iss_stall = w_stall;
   assign bus.lu_ready  = w_lu_ready;
   assign bus.rf_wr     = r_rf_wr;
   assign bus.rf_addr   = r_rf_addr;
   assign bus.rf_data   = r_rf_data;
   assign bus.pend      = r_pend;
endmodule

// File: tb/tb_rf_port_sched.sv
// Directed vector bench for rf_port_sched: a cycle table with expected outputs plus an async-reset sequence.
module tb_rf_port_sched;
   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   rf_port_sched_if #(.AW(5), .DW(32)) bus ();

   rf_port_sched #(.AW(5), .DW(32), .MAX_LONG(4), .STARVE_LIM(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [4:0]  rs, rt, rd;
      logic        wr, lg;
      logic        wbv;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic        luv;
      logic [4:0]  lua;
      logic [31:0] lud;
      logic        e_stall, e_lurdy, e_wr;
      logic [4:0]  e_addr;
      logic [31:0] e_data, e_pend;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic iv, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic wr, input logic lg,
                      input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                      input logic luv, input logic [4:0] lua, input logic [31:0] lud,
                      input logic es, input logic elr, input logic ewr, input logic [4:0] ea,
                      input logic [31:0] ed, input logic [31:0] ep);
      vec_t v;
      v.iv = iv; v.rs = rs; v.rt = rt; v.rd = rd; v.wr = wr; v.lg = lg;
      v.wbv = wbv; v.wba = wba; v.wbd = wbd;
      v.luv = luv; v.lua = lua; v.lud = lud;
      v.e_stall = es; v.e_lurdy = elr; v.e_wr = ewr; v.e_addr = ea; v.e_data = ed; v.e_pend = ep;
      tv.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.iss_valid = 1'b0; bus.iss_rs = 5'd0; bus.iss_rt = 5'd0; bus.iss_rd = 5'd0;
      bus.iss_wr = 1'b0; bus.iss_long = 1'b0;
      bus.wb_valid = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
      bus.lu_valid = 1'b0; bus.lu_addr = 5'd0; bus.lu_data = 32'd0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      drive_idle();
      reset = 1'b0;

      // iv rs rt rd wr lg | wbv wba wbd | luv lua lud | stall lurdy | rf_wr rf_addr rf_data pend
      add(0, 5'd0, 5'd0, 5'd0, 0, 0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0,  0, 5'd0, 32'h0, 32'h0);
      add(1, 5'd1, 5'd2, 5'd5, 1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0,  0, 5'd0, 32'h0, 32'h20);
      add(1, 5'd0, 5'd0, 5'd5, 1, 0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 0,  0, 5'd0, 32'h0, 32'h20);
      add(1, 5'd5, 5'd0, 5'd6, 1, 0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 0,  0, 5'd0, 32'h0, 32'h20);
      add(1, 5'd5, 5'd0, 5'd6, 1, 0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 0,  0, 5'd0, 32'h0, 32'h20);
      add(1, 5'd5, 5'd0, 5'd6, 1, 0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 0,  0, 5'd0, 32'h0, 32'h20);
      add(1, 5'd5, 5'd0, 5'd6, 1, 0,  0, 5'd0, 32'h0,  1, 5'd5, 32'hDEADBEEF,  1, 1,  1, 5'd5, 32'hDEADBEEF, 32'h0);
      add(1, 5'd5, 5'd0, 5'd6, 1, 0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0,  0, 5'd5, 32'hDEADBEEF, 32'h0);
      // WB/LU conflict, then LU accept with nothing outstanding
      add(0, 5'd0, 5'd0, 5'd0, 0, 0,  1, 5'd3, 32'h11,  1, 5'd7, 32'h22,  0, 0,  1, 5'd3, 32'h11, 32'h0);
      add(0, 5'd0, 5'd0, 5'd0, 0, 0,  0, 5'd0, 32'h0,   1, 5'd7, 32'h22,  0, 1,  1, 5'd7, 32'h22, 32'h0);
      // fill to MAX_LONG, fifth long op waits for one accept
      add(1, 5'd0, 5'd0, 5'd8,  1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0,  0, 5'd7, 32'h22, 32'h100);
      add(1, 5'd0, 5'd0, 5'd9,  1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0,  0, 5'd7, 32'h22, 32'h300);
      add(1, 5'd0, 5'd0, 5'd10, 1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0,  0, 5'd7, 32'h22, 32'h700);
      add(1, 5'd0, 5'd0, 5'd11, 1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0,  0, 5'd7, 32'h22, 32'hF00);
      add(1, 5'd0, 5'd0, 5'd12, 1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 0,  0, 5'd7, 32'h22, 32'hF00);
      add(1, 5'd0, 5'd0, 5'd12, 1, 1,  0, 5'd0, 32'h0,  1, 5'd8, 32'h88,  1, 1,  1, 5'd8, 32'h88, 32'hE00);
      add(1, 5'd0, 5'd0, 5'd12, 1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0,  0, 5'd8, 32'h88, 32'h1E00);
      // starvation: 8 denied cycles, then forced bubble
      for (int i = 0; i < 8; i++) begin
         add(1, 5'd1, 5'd2, 5'd3, 1, 0,  1, 5'd2, 32'h55,  1, 5'd9, 32'h99,  0, 0,  1, 5'd2, 32'h55, 32'h1E00);
      end
      add(1, 5'd1, 5'd2, 5'd3, 1, 0,  1, 5'd2, 32'h55,  1, 5'd9, 32'h99,  1, 0,  1, 5'd2, 32'h55, 32'h1E00);
      add(1, 5'd1, 5'd2, 5'd3, 1, 0,  0, 5'd0, 32'h0,   1, 5'd9, 32'h99,  1, 1,  1, 5'd9, 32'h99, 32'h1C00);
      add(1, 5'd1, 5'd2, 5'd3, 1, 0,  0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   0, 0,  0, 5'd9, 32'h99, 32'h1C00);
      // LU write to $0: consumed, no file write, count drops 3 -> 2 (two more longs fit, third stalls)
      add(0, 5'd0, 5'd0, 5'd0,  0, 0,  0, 5'd0, 32'h0,  1, 5'd0, 32'h77,  0, 1,  0, 5'd0, 32'h77, 32'h1C00);
      add(1, 5'd0, 5'd0, 5'd13, 1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,   0, 0,  0, 5'd0, 32'h77, 32'h3C00);
      add(1, 5'd0, 5'd0, 5'd14, 1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,   0, 0,  0, 5'd0, 32'h77, 32'h7C00);
      add(1, 5'd0, 5'd0, 5'd15, 1, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,   1, 0,  0, 5'd0, 32'h77, 32'h7C00);

      #12;
      chk("reset_rf_wr",   -1, 32'(bus.rf_wr),   32'h0);
      chk("reset_pend",    -1, bus.pend,         32'h0);
      chk("reset_rf_addr", -1, 32'(bus.rf_addr), 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_stall",  -1, 32'(bus.iss_stall), 32'h0);
      chk("idle_lurdy",  -1, 32'(bus.lu_ready),  32'h0);

      for (int i = 0; i < tv.size(); i++) begin
         bus.iss_valid = tv[i].iv; bus.iss_rs = tv[i].rs; bus.iss_rt = tv[i].rt; bus.iss_rd = tv[i].rd;
         bus.iss_wr = tv[i].wr; bus.iss_long = tv[i].lg;
         bus.wb_valid = tv[i].wbv; bus.wb_addr = tv[i].wba; bus.wb_data = tv[i].wbd;
         bus.lu_valid = tv[i].luv; bus.lu_addr = tv[i].lua; bus.lu_data = tv[i].lud;
         #1;
         chk("iss_stall", i, 32'(bus.iss_stall), 32'(tv[i].e_stall));
         chk("lu_ready",  i, 32'(bus.lu_ready),  32'(tv[i].e_lurdy));
         @(posedge clk);
         #1;
         chk("rf_wr",   i, 32'(bus.rf_wr),   32'(tv[i].e_wr));
         chk("rf_addr", i, 32'(bus.rf_addr), 32'(tv[i].e_addr));
         chk("rf_data", i, bus.rf_data,      tv[i].e_data);
         chk("pend",    i, bus.pend,         tv[i].e_pend);
      end

      // async reset with pend=0x120 and a write in flight
      drive_idle();
      reset = 1'b0;
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_long = 1'b1; bus.iss_rd = 5'd5;
      @(posedge clk);
      #1;
      bus.iss_rd = 5'd8;
      @(posedge clk);
      #1;
      drive_idle();
      bus.wb_valid = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hCAFE;
      @(posedge clk);
      #1;
      drive_idle();
      chk("pre_rst_pend",  100, bus.pend,         32'h120);
      chk("pre_rst_rf_wr", 100, 32'(bus.rf_wr),   32'h1);
      chk("pre_rst_addr",  100, 32'(bus.rf_addr), 32'h4);
      #1;
      reset = 1'b0;
      #1;
      chk("async_pend",    101, bus.pend,         32'h0);
      chk("async_rf_wr",   101, 32'(bus.rf_wr),   32'h0);
      chk("async_rf_addr", 101, 32'(bus.rf_addr), 32'h0);
      chk("async_rf_data", 101, bus.rf_data,      32'h0);
      #20;
      reset = 1'b1;
      @(posedge clk);
      #1;
      bus.iss_valid = 1'b1; bus.iss_rs = 5'd5; bus.iss_rt = 5'd8;
      #1;
      chk("post_rst_stall", 102, 32'(bus.iss_stall), 32'h0);
      drive_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end
endmodule

// File: doc/rf_port_sched.md
Name: rf_port_sched

Overview:
Write-port scheduler and scoreboard for the 31-entry register file.
- Arbitrates the single register-file write port between the pipeline writeback stage and the long-latency unit (mul/div/load-miss).
- Tracks registers with outstanding long-latency writes and stalls issue on RAW/WAW hazards against them.
- Sits between the decode/issue stage, the WB stage, the long unit and the register-file write port.

Parameters:
- AW, 5, register address width
- DW, 32, data width
- MAX_LONG, 4, max outstanding long-latency writes (1..15)
- STARVE_LIM, 8, consecutive denied long-unit cycles before a forced issue bubble

Ports:
- clk  in  1  clock, posedge
- reset  in  1  asynchronous, active-low
- iss_valid  in  1  instruction presented at issue
- iss_rs  in  AW  source 1
- iss_rt  in  AW  source 2
- iss_rd  in  AW  destination
- iss_wr  in  1  instruction writes iss_rd
- iss_long  in  1  destination is written by the long unit
- iss_stall  out  1  hold issue this cycle
- wb_valid  in  1  pipeline WB write request; can never be refused
- wb_addr  in  AW  WB destination
- wb_data  in  DW  WB data
- lu_valid  in  1  long-unit result available
- lu_addr  in  AW  long-unit destination
- lu_data  in  DW  long-unit data
- lu_ready  out  1  long-unit result accepted this cycle
- rf_wr  out  1  register-file write enable (registered)
- rf_addr  out  AW  register-file write address (registered)
- rf_data  out  DW  register-file write data (registered)
- pend  out  32  scoreboard vector; bit0 always 0

Behaviour:
Reset (async, reset=0):
- pend=0, long-op count=0, starve count=0.
- rf_wr=0, rf_addr=0, rf_data=0.
- lu_ready and iss_stall are combinational and follow the reset state of the registers they depend on.

Arbitration (combinational, per cycle):
- WB has fixed priority.
- lu_ready = lu_valid & ~wb_valid.
- Grant source: WB if wb_valid; else LU if lu_valid; else none.

Write port register (posedge):
- rf_wr <= granted & (granted addr != 0).
- rf_addr/rf_data <= granted source's addr/data; they hold the previous value when nothing is granted.
- A granted write at edge N is presented throughout cycle N+1; the register file captures it on that cycle's negedge.
- Writes to $0 are consumed (lu_ready still 1) but never reach the file.

Scoreboard:
- iss_fire = iss_valid & ~iss_stall.
- Set: pend[iss_rd] <= 1 on iss_fire & iss_wr & iss_long & iss_rd!=0.
- Clear: pend[lu_addr] <= 0 on lu_valid & lu_ready.
- Set and clear of different registers in one cycle both take effect.
- Same-register set/clear in one cycle cannot occur, because issue is stalled on pend[rd].
- Count: +1 on long fire (including rd=0), -1 on LU accept; both in one cycle leaves it unchanged.
- LU accept with count=0 is a protocol error: count saturates at 0 and pend is unchanged.

Stall (combinational, uses registered state only, no bypass):
- iss_stall = iss_valid & (H | F | S), where:
  - H (hazard) = pend[iss_rs] | pend[iss_rt] | (iss_wr & pend[iss_rd])
  - F (full) = iss_long & count==MAX_LONG
  - S (starve) = starve_force
- An instruction stalled because of an LU result accepted at edge N issues in cycle N+1; its combinational read then sees the value after the negedge write in N+1.

Starvation guard:
- Starve counter increments on lu_valid & ~lu_ready.
- It resets to 0 on LU accept or when lu_valid=0.
- starve_force = (counter >= STARVE_LIM).
- The forced issue bubble drains WB within the pipeline depth. Once WB is idle the LU is accepted and the counter clears.

Reset mid-operation:
- Scoreboard, count and any in-flight rf_wr are discarded immediately.
- The long unit must be reset by the same signal.

Test Plan:
1. Reset release, idle inputs → rf_wr=0, pend=0, iss_stall=0, lu_ready=0.
2. Long-op RAW and release:
   - Issue long rd=5 at cycle 1 → pend[5]=1 from cycle 2.
   - Issue rs=5 at cycle 3 → iss_stall=1 until LU accept.
   - lu_valid addr=5 data=0xDEADBEEF at cycle 6 → cycle 7: rf_wr=1, rf_addr=5, rf_data=0xDEADBEEF, pend[5]=0, iss_stall=0.
3. Same-cycle conflict: wb_valid addr=3 data=0x11 and lu_valid addr=7 data=0x22 together.
   - Cycle +1: rf_addr=3, lu_ready=0 during the conflict.
   - Next cycle with WB idle: rf_addr=7, rf_data=0x22.
4. Count limit: with MAX_LONG=4, issue 4 long ops (rd=8..11) → 5th long op (rd=12) stalls. One LU accept → 5th issues the next cycle.
5. Starvation: wb_valid held high with lu_valid high for 8 cycles → iss_stall=1 from cycle 9. When WB drops, LU accepted the same cycle and the stall clears after that cycle.
6. $0 and async reset:
   - LU addr=0 → lu_ready=1, rf_wr=0, count decremented.
   - reset asserted with pend=0x0000_0120 and rf_wr=1 → pend=0 and rf_wr=0 immediately, without a clock edge.
